// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
interface pc_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/pc_fetch_unit.sv
// MIPS fetch front end: PC register, redirect mux, imem handshake and a
// single registered instruction slot toward decode.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic [31:0]             pc_out,
    input  logic [31:0]             pc_plus4,
    pc_fetch_unit_if.master         imem,
    output logic [31:0]             instr_out,
    output logic                    instr_valid,
    input  logic                    id_stall,
    input  logic                    branch_taken,
    input  logic [31:0]             branch_target,
    input  logic                    jump_en,
    input  logic [31:0]             jump_target,
    input  logic                    exc_en,
    output logic                    misalign_err
);

    typedef enum logic [1:0] {BOOT, FETCH, FLUSH} state_t;

    state_t      state, state_next;
    logic        redirect;
    logic [31:0] raw_target;
    logic        misaligned;
    logic [31:0] redirect_pc;
    logic        accept;

    assign redirect = exc_en | jump_en | branch_taken;

    // Exception outranks jump, jump outranks branch; EXC_VECTOR is aligned,
    // so only jump/branch targets can be flagged.
    always_comb begin
        raw_target = branch_target;
        misaligned = 1'b0;
        if (exc_en) begin
            raw_target = EXC_VECTOR;
        end else if (jump_en) begin
            raw_target = jump_target;
            misaligned = (jump_target[1:0] != 2'b00);
        end else if (branch_taken) begin
            raw_target = branch_target;
            misaligned = (branch_target[1:0] != 2'b00);
        end
    end

    assign redirect_pc = misaligned ? EXC_VECTOR : raw_target;

    assign imem.imem_req  = (state == FETCH) && !(instr_valid && id_stall) && !redirect;
    assign imem.imem_addr = pc_out;
    assign accept         = imem.imem_req && imem.imem_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= BOOT;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (redirect) begin
            state_next = FLUSH;
        end else begin
            case (state)
                BOOT:    state_next = FETCH;
                FLUSH:   state_next = FETCH;
                FETCH:   state_next = FETCH;
                default: state_next = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_out       <= RESET_PC;
            instr_out    <= 32'h0;
            instr_valid  <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= redirect && misaligned;
            if (redirect) begin
                pc_out      <= redirect_pc;
                instr_valid <= 1'b0;
            end else if (accept) begin
                // Accept implies any held instruction is handed off this edge.
                instr_out   <= imem.imem_rdata;
                instr_valid <= 1'b1;
                pc_out      <= pc_plus4;
            end else if (instr_valid && !id_stall) begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch front end of the MIPS core.
- Holds the program counter and drives it to the PC+4 adder (fixed increment 4).
- Consumes the adder's result as the sequential next PC, redirects on exception, jump or branch, and runs the instruction-memory req/ready handshake.
- Presents one registered instruction at a time to decode, with stall back-pressure.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0080, redirect address for exceptions and misaligned targets.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  reset: synchronous, active-low.
- pc_out  output  32  current PC; feeds the PC+4 adder input.
- pc_plus4  input  32  adder result (pc_out + 4), combinational from pc_out.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address; always equals pc_out.
- imem_ready  input  1  memory returns imem_rdata this cycle; may assert in the same cycle as imem_req.
- imem_rdata  input  32  fetched instruction word.
- instr_out  output  32  registered instruction to decode.
- instr_valid  output  1  instr_out holds a valid instruction.
- id_stall  input  1  decode cannot accept instr_out this cycle.
- branch_taken  input  1  branch redirect request.
- branch_target  input  32  branch destination.
- jump_en  input  1  jump redirect request.
- jump_target  input  32  jump destination.
- exc_en  input  1  exception redirect request.
- misalign_err  output  1  one-cycle pulse: a redirect target had [1:0] != 0.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - pc_out=RESET_PC, instr_out=0, instr_valid=0, misalign_err=0, state=BOOT.
  - Reset asserted mid-handshake abandons the fetch; no instruction is captured.
- States:
  - BOOT: one cycle, imem_req=0, then go to FETCH.
  - FETCH: normal fetching.
  - FLUSH: one bubble cycle after a redirect, imem_req=0, then go to FETCH.
- imem_req = (state==FETCH) && !(instr_valid && id_stall) && !redirect.
  - Memory is read-only, so the request may be withdrawn before ready without side effects.
  - imem_ready is ignored whenever imem_req=0.
- Accept: imem_req && imem_ready at an edge, with no redirect:
  - instr_out <= imem_rdata, instr_valid <= 1, pc_out <= pc_plus4.
  - Single-cycle memory therefore gives 1 instruction per cycle, with instruction latency 1 cycle from req.
- Decode hand-off: an instruction transfers at an edge where instr_valid=1 and id_stall=0.
  - If that edge has no accept, instr_valid <= 0.
  - While id_stall=1 with instr_valid=1: instr_out and pc_out are held, and no request is issued.
- Redirect: redirect = exc_en | jump_en | branch_taken. Priority is exc_en > jump_en > branch_taken; target is EXC_VECTOR, jump_target or branch_target respectively.
- On a redirect edge:
  - pc_out <= target, instr_valid <= 0 (flush), state <= FLUSH.
  - Redirect overrides id_stall, and overrides any same-cycle imem_ready (the data is discarded).
- Misaligned target (jump or branch target [1:0] != 0):
  - pc_out <= EXC_VECTOR instead of the target.
  - misalign_err=1 for exactly the following cycle.
- exc_en to EXC_VECTOR never flags, since EXC_VECTOR is aligned.
- Redirect during FLUSH or BOOT: pc_out updates to the new target, and the state becomes or stays FLUSH.
- Wrap-around: pc_plus4 from 32'hFFFF_FFFC is 32'h0000_0000; it is accepted as-is with no error.
- Redirect and reset in the same edge: reset wins.

Test Plan:
- Reset, then imem_ready tied 1 with rdata = addr ^ 32'hA5A5_A5A5 → BOOT for 1 cycle; pc_out sequence 0,4,8,C; instr_valid from cycle 2; instr_out matches each address.
- id_stall=1 for 3 cycles with instr_valid=1 → imem_req=0, pc_out and instr_out frozen; on release the next fetch resumes at the held pc_out.
- At pc 0x10 assert jump_en (target 0x200) together with branch_taken (target 0x300) and imem_ready=1 → pc_out=0x200, instr_valid=0 for the flush and bubble cycles, fetch resumes at 0x200.
- branch_taken with branch_target=0x102 → pc_out=0x80, misalign_err high exactly 1 cycle.
- imem_ready delayed 2 cycles; assert rst_n=0 during the wait → pc_out=RESET_PC, instr_valid=0, no capture of the late rdata.
- Force pc to 0xFFFF_FFFC via jump → the next accept yields pc_out=0x0000_0000 and misalign_err stays 0.
